// File: rtl/of_pipe_stage.sv
// SimpleRISC operand-fetch stage: decode, immediate/branch-target generation, register read,
// RAW/WAW scoreboard and a registered valid/ready output. Optional macro: OF_WB_BYPASS_EN.
module of_pipe_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 16,
    localparam int RAW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,

    output logic [RAW-1:0]  rf_addr1,
    output logic [RAW-1:0]  rf_addr2,
    input  logic [XLEN-1:0] rf_data1,
    input  logic [XLEN-1:0] rf_data2,

    input  logic            wb_en,
    input  logic [RAW-1:0]  wb_addr,
    input  logic [XLEN-1:0] wb_data,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_opcode,
    output logic            out_I,
    output logic [RAW-1:0]  out_rd,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_immx,
    output logic [XLEN-1:0] out_branch_target,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2
);

    localparam logic [4:0]     OP_ST   = 5'd15;
    localparam logic [4:0]     OP_CALL = 5'd19;
    localparam logic [4:0]     OP_RET  = 5'd20;
    localparam logic [RAW-1:0] REG_RA  = RAW'(NREG - 1);

    function automatic logic [RAW-1:0] reg_field(input logic [3:0] f);
        return RAW'(f);
    endfunction

    function automatic logic writes_rd(input logic [4:0] op);
        case (op)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4,
            5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12,
            5'd14:   writes_rd = 1'b1;
            default: writes_rd = 1'b0;
        endcase
    endfunction

    logic [4:0]      opcode;
    logic            imm_flag;
    logic [RAW-1:0]  rd;
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;
    logic [RAW-1:0]  dest;
    logic            is_ret;
    logic            is_st;
    logic            is_writer;
    logic            chk_src2;
    logic [XLEN-1:0] immx;
    logic [XLEN-1:0] branch_target;

    assign opcode    = in_instr[31:27];
    assign imm_flag  = in_instr[26];
    assign rd        = reg_field(in_instr[25:22]);
    assign rs1       = reg_field(in_instr[21:18]);
    assign rs2       = reg_field(in_instr[17:14]);
    assign is_ret    = (opcode == OP_RET);
    assign is_st     = (opcode == OP_ST);
    assign is_writer = writes_rd(opcode) || (opcode == OP_CALL);
    assign dest      = (opcode == OP_CALL) ? REG_RA : rd;
    assign chk_src2  = !imm_flag || is_st;

    assign rf_addr1 = is_ret ? REG_RA : rs1;
    assign rf_addr2 = is_st  ? rd     : rs2;

    // Modifier 11 is reserved and behaves like the default sign-extension.
    always_comb begin
        case (in_instr[17:16])
            2'b01:   immx = XLEN'(in_instr[15:0]);
            2'b10:   immx = XLEN'($signed({in_instr[15:0], 16'h0000}));
            default: immx = XLEN'($signed(in_instr[15:0]));
        endcase
    end

    assign branch_target = in_pc + XLEN'($signed({in_instr[26:0], 2'b00}));

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic            out_writer;
    logic [RAW-1:0]  out_dest;
    logic            held1;
    logic            held2;
    logic            held_d;
    logic            byp1;
    logic            byp2;
    logic            haz1;
    logic            haz2;
    logic            haz_d;
    logic            hazard;
    logic            out_fire;
    logic            load;
    logic [XLEN-1:0] op1_next;
    logic [XLEN-1:0] op2_next;

    // A writer still sitting in the output register has not reached the scoreboard yet.
    assign held1  = out_valid && out_writer && (out_dest == rf_addr1);
    assign held2  = out_valid && out_writer && (out_dest == rf_addr2);
    assign held_d = out_valid && out_writer && (out_dest == dest);

`ifdef OF_WB_BYPASS_EN
    assign byp1 = wb_en && (wb_addr == rf_addr1);
    assign byp2 = wb_en && (wb_addr == rf_addr2);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    // Destination matches never use the bypass: the busy bit must clear before a new writer claims it.
    assign haz1   = held1 || (busy[rf_addr1] && !byp1);
    assign haz2   = chk_src2 && (held2 || (busy[rf_addr2] && !byp2));
    assign haz_d  = is_writer && (held_d || busy[dest]);
    assign hazard = haz1 || haz2 || haz_d;

    assign in_ready = !rst && !flush && !hazard && (!out_valid || out_ready);
    assign load     = in_valid && in_ready;
    assign out_fire = out_valid && out_ready && !flush;

    assign op1_next = byp1 ? wb_data : rf_data1;
    assign op2_next = byp2 ? wb_data : rf_data2;

    always_comb begin
        busy_next = busy;
        if (wb_en) begin
            busy_next[wb_addr] = 1'b0;
        end
        if (out_fire && out_writer) begin
            busy_next[out_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid         <= 1'b0;
            out_opcode        <= '0;
            out_I             <= 1'b0;
            out_rd            <= '0;
            out_pc            <= '0;
            out_immx          <= '0;
            out_branch_target <= '0;
            out_op1           <= '0;
            out_op2           <= '0;
            out_writer        <= 1'b0;
            out_dest          <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid         <= 1'b1;
            out_opcode        <= opcode;
            out_I             <= imm_flag;
            out_rd            <= rd;
            out_pc            <= in_pc;
            out_immx          <= immx;
            out_branch_target <= branch_target;
            out_op1           <= op1_next;
            out_op2           <= op2_next;
            out_writer        <= is_writer;
            out_dest          <= dest;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_of_pipe_stage.sv
// Scoreboard bench for of_pipe_stage: directed test-plan cases followed by randomized traffic
// checked against a queue-based behavioural model of issue, hazards and writeback.
module tb_of_pipe_stage;
    localparam int XLEN = 32;
    localparam int NREG = 16;
    localparam int RAW  = 4;

    logic            clk = 1'b0;
    logic            rst, flush, in_valid, in_ready, wb_en, out_valid, out_ready, out_I;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc, rf_data1, rf_data2, wb_data;
    logic [RAW-1:0]  rf_addr1, rf_addr2, wb_addr, out_rd;
    logic [4:0]      out_opcode;
    logic [XLEN-1:0] out_pc, out_immx, out_branch_target, out_op1, out_op2;

    logic [XLEN-1:0] regs [NREG];
    assign rf_data1 = regs[rf_addr1];
    assign rf_data2 = regs[rf_addr2];

    always #5 clk = ~clk;

    of_pipe_stage #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode), .out_I(out_I),
        .out_rd(out_rd), .out_pc(out_pc), .out_immx(out_immx),
        .out_branch_target(out_branch_target), .out_op1(out_op1), .out_op2(out_op2)
    );

    typedef struct {
        logic [4:0]  opcode;
        logic        i;
        logic [3:0]  rd;
        logic [31:0] pc, immx, tgt, op1, op2;
    } exp_t;

    exp_t exp_q[$];
    int   flight_q[$];
    bit   hold_valid = 0, hold_writer = 0;
    int   hold_dest = 0;
    int   checks = 0, errors = 0;
    bit   last_in_ready, last_load;
    logic [3:0] last_rf_addr1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit writes(input logic [4:0] op);
        return (op <= 4) || (op >= 6 && op <= 12) || op == 14 || op == 19;
    endfunction
    function automatic int dest_of(input logic [31:0] ins);
        return (ins[31:27] == 19) ? 15 : int'(ins[25:22]);
    endfunction
    function automatic int src1_of(input logic [31:0] ins);
        return (ins[31:27] == 20) ? 15 : int'(ins[21:18]);
    endfunction
    function automatic int src2_of(input logic [31:0] ins);
        return (ins[31:27] == 15) ? int'(ins[25:22]) : int'(ins[17:14]);
    endfunction
    function automatic bit checks_src2(input logic [31:0] ins);
        return !ins[26] || ins[31:27] == 15;
    endfunction
    function automatic bit in_q(input int r);
        foreach (flight_q[j]) if (flight_q[j] == r) return 1;
        return 0;
    endfunction
    function automatic bit held(input int r);
        return hold_valid && hold_writer && hold_dest == r;
    endfunction
    function automatic bit bypassed(input int r, input bit we, input logic [3:0] wa);
`ifdef OF_WB_BYPASS_EN
        return we && int'(wa) == r;
`else
        return 0;
`endif
    endfunction
    function automatic bit src_blocked(input int r, input bit we, input logic [3:0] wa);
        return held(r) || (in_q(r) && !bypassed(r, we, wa));
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] ins);
        longint v = longint'(ins[15:0]);
        case (ins[17:16])
            2'b01:   ;
            2'b10:   v = v * 65536;
            default: if (v >= 32768) v = v - 65536;
        endcase
        return v[31:0];
    endfunction
    function automatic logic [31:0] tgt_of(input logic [31:0] ins, input logic [31:0] pc);
        longint off = longint'(ins[26:0]);
        longint t;
        if (off >= 64'sd67108864) off = off - 64'sd134217728;
        t = longint'(pc) + off * 4;
        return t[31:0];
    endfunction

    function automatic logic [31:0] mk_r(input int op, input int rd, input int rs1, input int rs2);
        return {5'(op), 1'b0, 4'(rd), 4'(rs1), 4'(rs2), 14'd0};
    endfunction
    function automatic logic [31:0] mk_i(input int op, input int rd, input int rs1, input int md,
                                         input int imm);
        return {5'(op), 1'b1, 4'(rd), 4'(rs1), 2'(md), 16'(imm)};
    endfunction

    task automatic drive_cycle(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                               input bit ordy, input bit fl, input bit r, input bit we,
                               input logic [3:0] wa, input logic [31:0] wd);
        bit   exp_rdy, load, fire;
        int   s1, s2;
        exp_t e;
        @(negedge clk);
        rst = r; in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
        wb_en = we; wb_addr = wa; wb_data = wd;
        #2;
        s1 = src1_of(ins);
        s2 = src2_of(ins);
        exp_rdy = !r && !fl && (!hold_valid || ordy) && !src_blocked(s1, we, wa)
                  && !(checks_src2(ins) && src_blocked(s2, we, wa))
                  && !(writes(ins[31:27]) && (held(dest_of(ins)) || in_q(dest_of(ins))));
        check("in_ready", in_ready, exp_rdy);
        check("out_valid", out_valid, hold_valid);
        check("rf_addr1", rf_addr1, s1);
        check("rf_addr2", rf_addr2, s2);
        last_in_ready = in_ready;
        last_rf_addr1 = rf_addr1;
        load = v && exp_rdy;
        fire = hold_valid && ordy && !fl && !r;
        last_load = load;
        if (load) begin
            e.opcode = ins[31:27]; e.i = ins[26]; e.rd = ins[25:22]; e.pc = pc;
            e.immx = imm_of(ins); e.tgt = tgt_of(ins, pc);
            e.op1 = bypassed(s1, we, wa) ? wd : regs[s1];
            e.op2 = bypassed(s2, we, wa) ? wd : regs[s2];
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (r) begin
            flight_q.delete();
            exp_q.delete();
            hold_valid = 0;
        end else begin
            if (fl && hold_valid) begin
                void'(exp_q.pop_front());
                hold_valid = 0;
            end
            if (we) begin
                regs[wa] = wd;
                for (int j = 0; j < flight_q.size(); j++)
                    if (flight_q[j] == int'(wa)) begin
                        flight_q.delete(j);
                        break;
                    end
            end
            if (fire) begin
                if (hold_writer) flight_q.push_back(hold_dest);
                hold_valid = 0;
            end
            if (load) begin
                hold_valid  = 1;
                hold_writer = writes(ins[31:27]);
                hold_dest   = dest_of(ins);
            end
        end
    endtask

    task automatic idle(input bit ordy);
        drive_cycle(0, 32'd0, 32'd0, ordy, 0, 0, 0, 4'd0, 32'd0);
    endtask

    task automatic wb_all();
        for (int k = 0; k < 24 && (flight_q.size() > 0 || hold_valid); k++) begin
            if (flight_q.size() > 0)
                drive_cycle(0, 32'd0, 32'd0, 1, 0, 0, 1, 4'(flight_q[0]), $urandom);
            else
                idle(1);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins = $urandom;
        ins[25:22] = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
        ins[21:18] = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
        if (!ins[26]) ins[17:14] = 4'($urandom_range(0, 5));
        return ins;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst && out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got pc %0h expected no output", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("out_opcode", out_opcode, e.opcode);
                    check("out_I", out_I, e.i);
                    check("out_rd", out_rd, e.rd);
                    check("out_pc", out_pc, e.pc);
                    check("out_immx", out_immx, e.immx);
                    check("out_branch_target", out_branch_target, e.tgt);
                    check("out_op1", out_op1, e.op1);
                    check("out_op2", out_op2, e.op2);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [31:0] cur, cpc, s_pc, s_op1, s_immx, wd;
        logic [3:0]  wa;
        bit          have, v, ordy, fl, we;
        for (int k = 0; k < NREG; k++) regs[k] = 32'h1000 + k;
        regs[1] = 5;
        regs[2] = 7;
        rst = 1; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
        repeat (2) @(posedge clk);

        // reset: outputs cleared, in_ready low even with a valid input
        drive_cycle(1, mk_r(0, 3, 1, 2), 32'h40, 1, 0, 1, 0, 4'd0, 32'd0);
        check("rst_out_op1", out_op1, 0);
        check("rst_out_immx", out_immx, 0);
        check("rst_out_target", out_branch_target, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_in_ready", last_in_ready, 0);

        drive_cycle(1, mk_r(0, 3, 1, 2), 32'h40, 1, 0, 0, 0, 4'd0, 32'd0);
        check("add_valid", out_valid, 1);
        check("add_op1", out_op1, 5);
        check("add_op2", out_op2, 7);
        check("add_rd", out_rd, 3);

        drive_cycle(1, mk_i(9, 7, 0, 0, 16'hFFFE), 32'h44, 1, 0, 0, 0, 4'd0, 32'd0);
        check("immx_mod00", out_immx, 32'hFFFF_FFFE);
        drive_cycle(1, mk_i(9, 8, 0, 1, 16'hFFFE), 32'h48, 1, 0, 0, 0, 4'd0, 32'd0);
        check("immx_mod01", out_immx, 32'h0000_FFFE);
        drive_cycle(1, mk_i(9, 10, 0, 2, 16'hFFFE), 32'h4C, 1, 0, 0, 0, 4'd0, 32'd0);
        check("immx_mod10", out_immx, 32'hFFFE_0000);
        wb_all();

        drive_cycle(1, {5'd18, 27'h7FF_FFFF}, 32'h100, 1, 0, 0, 0, 4'd0, 32'd0);
        check("branch_target", out_branch_target, 32'hFC);
        drive_cycle(1, {5'd20, 27'd0}, 32'h104, 1, 0, 0, 0, 4'd0, 32'd0);
        check("ret_rf_addr1", last_rf_addr1, 15);
        idle(1);

        // ld r4 then dependent add r5 = r4 + r1
        drive_cycle(1, mk_i(14, 4, 1, 0, 16'h10), 32'h200, 1, 0, 0, 0, 4'd0, 32'd0);
        idle(1);
        for (int k = 0; k < 2; k++) begin
            drive_cycle(1, mk_r(0, 5, 4, 1), 32'h204, 1, 0, 0, 0, 4'd0, 32'd0);
            check("raw_stall", last_in_ready, 0);
        end
        drive_cycle(1, mk_r(0, 5, 4, 1), 32'h204, 1, 0, 0, 1, 4'd4, 32'hABCD);
`ifdef OF_WB_BYPASS_EN
        check("bypass_issue", last_in_ready, 1);
`else
        check("wb_cycle_stall", last_in_ready, 0);
        drive_cycle(1, mk_r(0, 5, 4, 1), 32'h204, 1, 0, 0, 0, 4'd0, 32'd0);
        check("post_wb_issue", last_in_ready, 1);
`endif
        check("dep_op1", out_op1, 32'hABCD);
        wb_all();

        // downstream stall with a back-to-back valid input
        drive_cycle(1, mk_r(5, 0, 1, 2), 32'h300, 0, 0, 0, 0, 4'd0, 32'd0);
        s_pc = out_pc; s_op1 = out_op1; s_immx = out_immx;
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1, mk_r(5, 0, 2, 1), 32'h304, 0, 0, 0, 0, 4'd0, 32'd0);
            check("stall_in_ready", last_in_ready, 0);
            check("stall_pc_stable", out_pc, s_pc);
            check("stall_op1_stable", out_op1, s_op1);
            check("stall_immx_stable", out_immx, s_immx);
        end
        drive_cycle(1, mk_r(5, 0, 2, 1), 32'h304, 1, 0, 0, 0, 4'd0, 32'd0);
        check("stall_release", out_pc, 32'h304);
        idle(1);

        // flush kills held add r6; a reader of r6 must not stall afterwards
        drive_cycle(1, mk_r(0, 6, 1, 2), 32'h400, 0, 0, 0, 0, 4'd0, 32'd0);
        drive_cycle(0, 32'd0, 32'd0, 1, 1, 0, 0, 4'd0, 32'd0);
        check("flush_valid", out_valid, 0);
        drive_cycle(1, mk_r(0, 9, 6, 1), 32'h404, 1, 0, 0, 0, 4'd0, 32'd0);
        check("flush_no_stall", last_in_ready, 1);
        wb_all();

        // reset mid-stall discards the pending writer
        drive_cycle(1, mk_r(0, 11, 1, 2), 32'h500, 0, 0, 0, 0, 4'd0, 32'd0);
        drive_cycle(0, 32'd0, 32'd0, 1, 0, 1, 0, 4'd0, 32'd0);
        check("rst_mid_valid", out_valid, 0);
        drive_cycle(1, mk_r(0, 12, 11, 1), 32'h504, 1, 0, 0, 0, 4'd0, 32'd0);
        check("rst_mid_no_stall", last_in_ready, 1);
        wb_all();

        have = 0;
        cur = 0;
        cpc = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!have) begin
                cur  = rand_instr();
                cpc  = $urandom & 32'hFFFF_FFFC;
                have = 1;
            end
            v    = $urandom_range(0, 9) < 8;
            ordy = $urandom_range(0, 9) < 7;
            fl   = $urandom_range(0, 31) == 0;
            we   = 0;
            wa   = 0;
            wd   = 0;
            if (flight_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                we = 1;
                wa = 4'(flight_q[$urandom_range(0, flight_q.size() - 1)]);
                wd = $urandom;
            end
            drive_cycle(v, cur, cpc, ordy, fl, 0, we, wa, wd);
            if (last_load) have = 0;
        end
        wb_all();
        idle(1);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/of_pipe_stage.md
# of_pipe_stage

Registered, parametrised operand-fetch stage for the SimpleRISC pipeline, sitting between instruction fetch and execute. It decodes the instruction fields, extends the immediate, and computes the PC-relative branch target. It reads the register file and holds the result in an output pipeline register with valid/ready handshakes on both sides. A per-register scoreboard stalls issue on RAW/WAW hazards against instructions still in flight.

## Interface
- `XLEN`, 32, datapath width (immx, branch target, operands, PC); must be ≥ 32
- `NREG`, 16, architectural registers; register address width `RAW = $clog2(NREG)` (4 at default); ra = register NREG-1
- `clk` input 1 — single clock, all state on rising edge
- `rst` input 1 — synchronous, active-high reset
- `flush` input 1 — kill output-register contents and block input this cycle
- `in_valid` input 1 / `in_ready` output 1 — fetch-side handshake
- `in_instr` input 32 — instruction word
- `in_pc` input XLEN — PC of `in_instr`
- `rf_addr1`, `rf_addr2` output RAW — combinational register-file read addresses
- `rf_data1`, `rf_data2` input XLEN — combinational register-file read data
- `wb_en` input 1, `wb_addr` input RAW, `wb_data` input XLEN — writeback port (clears scoreboard)
- `out_valid` output 1 / `out_ready` input 1 — execute-side handshake
- `out_opcode` output 5, `out_I` output 1, `out_rd` output RAW, `out_pc` output XLEN
- `out_immx`, `out_branch_target`, `out_op1`, `out_op2` output XLEN

## Operation
- Decode from `in_instr`:
  - opcode = [31:27]; I = [26]; rd = [25:22]; rs1 = [21:18]; rs2 = [17:14]
  - Fields are zero-extended/truncated to RAW.
- Opcode decodes:
  - isRet = (opcode==20)
  - isSt = (opcode==15)
- `rf_addr1`:
  - ra when isRet
  - rs1 otherwise
- `rf_addr2`:
  - rd when isSt
  - rs2 otherwise
- Immediate, modifier [17:16]:
  - 00: sign-extend [15:0]
  - 01: zero-extend [15:0]
  - 10: {[15:0], 16'b0} then sign-extend to XLEN
  - 11: reserved, treated as 00
  - Always computed; don't-care to execute when I=0.
- Branch target: `in_pc` + (sign-extend [26:0] to XLEN) << 2, modulo 2^XLEN. Always computed, independent of I.
- Writer set:
  - opcodes 0–4, 6–12, 14 write rd
  - opcode 19 (call) writes ra
  - all others write nothing
- Sources checked for hazards:
  - src1 = `rf_addr1`, always checked
  - src2 = `rf_addr2`, checked when I=0 or isSt
- Scoreboard `busy[NREG]`:
  - set for the destination when the output register is accepted (`out_valid && out_ready && !flush`) and it holds a writer
  - cleared on `wb_en` at `wb_addr`
  - same-register set and clear in one cycle: set wins
- Hazard: any checked source, or the destination of a writer, is
  - marked in `busy`, or
  - equal to the destination of a valid writer in the output register.
  - Destination check prevents WAW and keeps the single-bit scoreboard exact.
- `in_ready` = !rst && !flush && !hazard && (!out_valid || out_ready). Combinational from `in_instr`; independent of `in_valid`.
- Load: on `in_valid && in_ready`, all decoded fields plus `rf_data` (or the bypass) are captured, and `out_valid` is set.
- Output register accepted without a new load: `out_valid` cleared.
- `flush`:
  - `out_valid` cleared, no load
  - `busy` unchanged, because older in-flight writers still write back

## Timing
- Latency: one cycle, accepted input → `out_valid` on the next edge.
- Throughput: one per cycle when there is no hazard and `out_ready`=1.
- Outputs hold stable while `out_valid && !out_ready`.
- Reset: `out_valid`=0, every `out_*` data output = 0, `busy` = all 0, `in_ready`=0 during reset.
- Reset or flush mid-stall: the pending output is discarded; no scoreboard bit is set for it.
- Writeback with the bypass compiled out:
  - the clearing `wb_en` cycle still stalls
  - issue occurs the following cycle
  - the register file provides write-before-read visibility the next cycle

## Configuration
- `OF_WB_BYPASS_EN` defined:
  - A source equal to `wb_addr` with `wb_en`=1 is not a hazard that cycle, even if busy.
  - `wb_data` replaces `rf_data` for that operand.
  - A destination match still stalls until the next cycle.
- `OF_WB_BYPASS_EN` undefined:
  - no bypass
  - an instruction dependent on a writeback issues one cycle after the `wb_en` cycle

## Test plan
- Reset, then `add` r3=r1+r2 (I=0), with `rf_data1`=5, `rf_data2`=7 → next cycle `out_valid`=1, `out_op1`=5, `out_op2`=7, `out_rd`=3.
- `mov` I=1 with modifier 00, imm 0xFFFE → `out_immx`=0xFFFFFFFE. Modifier 01 → 0x0000FFFE. Modifier 10 → 0xFFFE0000.
- `b` with [26:0]=0x7FFFFFF at pc=0x100 → `out_branch_target`=0xFC. `ret` → `rf_addr1`=15.
- `ld` r4 is accepted downstream, followed by `add` r5=r4+r1:
  - `in_ready`=0 until `wb_en`, `wb_addr`=4
  - with bypass, issue on the wb cycle with `out_op1`=`wb_data`
  - without bypass, issue one cycle later
- `out_ready`=0 for 3 cycles with back-to-back valid inputs → outputs stable, `in_ready`=0, no input lost.
- `flush` while the output holds `add` r6 → `out_valid`=0 next cycle, `busy[6]`=0, and a following reader of r6 issues without a stall.
